// File: rtl/sb_arb2.sv
// Two-master round-robin arbiter in front of a single sb_ slave; one transaction in flight.
// Define SB_ARB_FIXED_PRIO_EN to replace round robin with fixed priority (m1 wins ties).
module sb_arb2 (
  input  logic        sb_clk,
  input  logic        sb_rst_n,
  // master 0 (instruction fetch)
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m0_rready,
  input  logic        m0_wvalid,
  input  logic [31:0] m0_waddr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_wready,
  output logic        m0_bvalid,
  output logic        m0_bresp,
  input  logic        m0_bready,
  // master 1 (load/store)
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  input  logic        m1_rready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_waddr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_wready,
  output logic        m1_bvalid,
  output logic        m1_bresp,
  input  logic        m1_bready,
  // slave
  output logic        s_arvalid,
  output logic [31:0] s_araddr,
  input  logic        s_arready,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  output logic        s_rready,
  output logic        s_wvalid,
  output logic [31:0] s_waddr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_wready,
  input  logic        s_bvalid,
  input  logic        s_bresp,
  output logic        s_bready
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   last_grant;
  logic   winner;
  logic   rsp_done;

  logic [1:0]  arvalid_v, wvalid_v, rready_v, bready_v, req_v;
  logic [31:0] araddr_v [2];
  logic [31:0] waddr_v  [2];
  logic [31:0] wdata_v  [2];
  logic [3:0]  wstrb_v  [2];
  logic [1:0]  arready_v, wready_v, rvalid_v, bvalid_v, bresp_v;
  logic [31:0] rdata_v  [2];

  assign arvalid_v   = {m1_arvalid, m0_arvalid};
  assign wvalid_v    = {m1_wvalid, m0_wvalid};
  assign rready_v    = {m1_rready, m0_rready};
  assign bready_v    = {m1_bready, m0_bready};
  assign araddr_v[0] = m0_araddr;
  assign araddr_v[1] = m1_araddr;
  assign waddr_v[0]  = m0_waddr;
  assign waddr_v[1]  = m1_waddr;
  assign wdata_v[0]  = m0_wdata;
  assign wdata_v[1]  = m1_wdata;
  assign wstrb_v[0]  = m0_wstrb;
  assign wstrb_v[1]  = m1_wstrb;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign req_v[gi]   = arvalid_v[gi] | wvalid_v[gi];
      assign rdata_v[gi] = (state_reg == RD_WAIT && owner_reg == 1'(gi)) ? s_rdata : 32'd0;
      assign bresp_v[gi] = (state_reg == WR_WAIT && owner_reg == 1'(gi)) ? s_bresp : 1'b0;
    end
  endgenerate

  assign m0_arready = arready_v[0];
  assign m1_arready = arready_v[1];
  assign m0_wready  = wready_v[0];
  assign m1_wready  = wready_v[1];
  assign m0_rvalid  = rvalid_v[0];
  assign m1_rvalid  = rvalid_v[1];
  assign m0_rdata   = rdata_v[0];
  assign m1_rdata   = rdata_v[1];
  assign m0_bvalid  = bvalid_v[0];
  assign m1_bvalid  = bvalid_v[1];
  assign m0_bresp   = bresp_v[0];
  assign m1_bresp   = bresp_v[1];

  // Tie goes to the master that was not served last; with last_grant=0 m1 always wins.
  assign winner = req_v[1] & (~req_v[0] | ~last_grant);

  assign rsp_done = (state_reg == RD_WAIT && s_rvalid && rready_v[owner_reg]) ||
                    (state_reg == WR_WAIT && s_bvalid && bready_v[owner_reg]);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    s_arvalid  = 1'b0;
    s_araddr   = 32'd0;
    s_wvalid   = 1'b0;
    s_waddr    = 32'd0;
    s_wdata    = 32'd0;
    s_wstrb    = 4'd0;
    s_rready   = 1'b0;
    s_bready   = 1'b0;
    arready_v  = 2'b00;
    wready_v   = 2'b00;
    rvalid_v   = 2'b00;
    bvalid_v   = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|req_v) begin
          s_arvalid = arvalid_v[winner];
          s_araddr  = araddr_v[winner];
          // A master presenting both read and write gets the read first.
          s_wvalid  = wvalid_v[winner] & ~arvalid_v[winner];
          s_waddr   = waddr_v[winner];
          s_wdata   = wdata_v[winner];
          s_wstrb   = wstrb_v[winner];
          arready_v[winner] = s_arready;
          wready_v[winner]  = s_wready & ~arvalid_v[winner];
          if (arvalid_v[winner] && s_arready) begin
            state_next = RD_WAIT;
            owner_next = winner;
          end else if (wvalid_v[winner] && s_wready) begin
            state_next = WR_WAIT;
            owner_next = winner;
          end
        end
      end
      RD_WAIT: begin
        rvalid_v[owner_reg] = s_rvalid;
        s_rready            = rready_v[owner_reg];
        if (rsp_done) state_next = IDLE;
      end
      WR_WAIT: begin
        bvalid_v[owner_reg] = s_bvalid;
        s_bready            = bready_v[owner_reg];
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sb_clk or negedge sb_rst_n) begin
    if (!sb_rst_n) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

`ifdef SB_ARB_FIXED_PRIO_EN
  assign last_grant = 1'b0;
`else
  logic last_grant_reg;

  always_ff @(posedge sb_clk or negedge sb_rst_n) begin
    if (!sb_rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (rsp_done) begin
      last_grant_reg <= owner_reg;
    end
  end

  assign last_grant = last_grant_reg;
`endif

endmodule

// File: tb/tb_sb_arb2.sv
// Directed bench for sb_arb2 with a 1-cycle RAM slave model and a response scoreboard.
module tb_sb_arb2;

  logic        sb_clk, sb_rst_n;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic        m0_wvalid, m0_wready, m0_bvalid, m0_bresp, m0_bready;
  logic [31:0] m0_araddr, m0_rdata, m0_waddr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        m1_wvalid, m1_wready, m1_bvalid, m1_bresp, m1_bready;
  logic [31:0] m1_araddr, m1_rdata, m1_waddr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_wvalid, s_wready, s_bvalid, s_bresp, s_bready;
  logic [31:0] s_araddr, s_rdata, s_waddr, s_wdata;
  logic [3:0]  s_wstrb;

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  sb_arb2 dut (
    .sb_clk(sb_clk), .sb_rst_n(sb_rst_n),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m0_wvalid(m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bready(m0_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .m1_wvalid(m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
    .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  // RAM slave: always ready, response one cycle after the handshake.
  logic [31:0] mem [0:15];
  assign s_arready = 1'b1;
  assign s_wready  = 1'b1;
  assign s_bresp   = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[4] = 32'hCAFE_0001;
    mem[8] = 32'h5555_AAAA;
  end

  always @(posedge sb_clk or negedge sb_rst_n) begin
    if (!sb_rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= 32'd0;
      s_bvalid <= 1'b0;
    end else begin
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[s_araddr[5:2]];
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
      if (s_wvalid && s_wready) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_waddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        s_bvalid <= 1'b1;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input bit m, input bit wr, input logic [31:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      check32("sb_unexpected_rsp", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check1("sb_owner", m, e.m);
      check1("sb_kind", wr, e.wr);
      check32("sb_data", data, e.data);
    end
  endtask

  // Response monitor: any completed response handshake must match the queue head.
  always @(negedge sb_clk) begin
    if (sb_rst_n) begin
      if (m0_rvalid && m0_rready) sb_pop(1'b0, 1'b0, m0_rdata);
      if (m1_rvalid && m1_rready) sb_pop(1'b1, 1'b0, m1_rdata);
      if (m0_bvalid && m0_bready) sb_pop(1'b0, 1'b1, {31'd0, m0_bresp});
      if (m1_bvalid && m1_bready) sb_pop(1'b1, 1'b1, {31'd0, m1_bresp});
    end
  end

  task automatic tick();
    @(posedge sb_clk);
    #2;
  endtask

  task automatic rd_single(input bit m, input logic [31:0] addr, input logic [31:0] data);
    if (m) begin m1_arvalid = 1'b1; m1_araddr = addr; end
    else   begin m0_arvalid = 1'b1; m0_araddr = addr; end
    sb_q.push_back('{m, 1'b0, data});
    #1;
    check1("rd_arready", m ? m1_arready : m0_arready, 1'b1);
    check1("rd_other_arready", m ? m0_arready : m1_arready, 1'b0);
    check32("rd_s_araddr", s_araddr, addr);
    tick();
    m0_arvalid = 1'b0; m0_araddr = 32'd0;
    m1_arvalid = 1'b0; m1_araddr = 32'd0;
    #1;
    check1("rd_rvalid", m ? m1_rvalid : m0_rvalid, 1'b1);
    check1("rd_other_rvalid", m ? m0_rvalid : m1_rvalid, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    sb_rst_n   = 1'b0;
    m0_arvalid = 1'b0; m0_araddr = 32'd0; m0_rready = 1'b1;
    m0_wvalid  = 1'b0; m0_waddr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0; m0_bready = 1'b1;
    m1_arvalid = 1'b0; m1_araddr = 32'd0; m1_rready = 1'b1;
    m1_wvalid  = 1'b0; m1_waddr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0; m1_bready = 1'b1;
    repeat (2) tick();
    sb_rst_n = 1'b1;
    #1;
    check1("rst_s_arvalid", s_arvalid, 1'b0);
    check1("rst_s_wvalid", s_wvalid, 1'b0);
    check1("rst_m0_arready", m0_arready, 1'b0);
    check1("rst_m1_wready", m1_wready, 1'b0);
    check1("rst_m0_rvalid", m0_rvalid, 1'b0);
    check1("rst_m1_bvalid", m1_bvalid, 1'b0);
    check1("rst_s_rready", s_rready, 1'b0);
    check32("rst_s_araddr", s_araddr, 32'd0);

    // Simultaneous reads right after reset: m0 first, then m1.
    tick();
    m0_arvalid = 1'b1; m0_araddr = 32'h10;
    m1_arvalid = 1'b1; m1_araddr = 32'h20;
    sb_q.push_back('{1'b0, 1'b0, 32'hCAFE_0001});
    sb_q.push_back('{1'b1, 1'b0, 32'h5555_AAAA});
    #1;
    check1("p1_m0_arready", m0_arready, 1'b1);
    check1("p1_m1_arready", m1_arready, 1'b0);
    check32("p1_s_araddr0", s_araddr, 32'h10);
    tick();
    m0_arvalid = 1'b0; m0_araddr = 32'd0;
    #1;
    check1("p1_m0_rvalid", m0_rvalid, 1'b1);
    check1("p1_m1_rvalid", m1_rvalid, 1'b0);
    check1("p1_m1_arready_wait", m1_arready, 1'b0);
    tick();
    #1;
    check1("p1_m1_arready", m1_arready, 1'b1);
    check32("p1_s_araddr1", s_araddr, 32'h20);
    tick();
    m1_arvalid = 1'b0; m1_araddr = 32'd0;
    #1;
    check1("p1_m1_rvalid", m1_rvalid, 1'b1);
    tick();

    // Single m0 read, then a second tie goes to m1.
    rd_single(1'b0, 32'h10, 32'hCAFE_0001);
    m0_arvalid = 1'b1; m0_araddr = 32'h10;
    m1_arvalid = 1'b1; m1_araddr = 32'h20;
    sb_q.push_back('{1'b1, 1'b0, 32'h5555_AAAA});
    sb_q.push_back('{1'b0, 1'b0, 32'hCAFE_0001});
    #1;
    check1("p2_m1_arready", m1_arready, 1'b1);
    check1("p2_m0_arready", m0_arready, 1'b0);
    tick();
    m1_arvalid = 1'b0; m1_araddr = 32'd0;
    #1;
    check1("p2_m1_rvalid", m1_rvalid, 1'b1);
    tick();
    #1;
    check1("p2_m0_arready_late", m0_arready, 1'b1);
    tick();
    m0_arvalid = 1'b0; m0_araddr = 32'd0;
    #1;
    check1("p2_m0_rvalid", m0_rvalid, 1'b1);
    tick();

    // Mixed: m0 write vs m1 read to 0x20 after m0 was served; m1 reads old data first.
    m0_wvalid = 1'b1; m0_waddr = 32'h20; m0_wdata = 32'h1234_5678; m0_wstrb = 4'hF;
    m1_arvalid = 1'b1; m1_araddr = 32'h20;
    sb_q.push_back('{1'b1, 1'b0, 32'h5555_AAAA});
    sb_q.push_back('{1'b0, 1'b1, 32'd0});
    #1;
    check1("mx_m1_arready", m1_arready, 1'b1);
    check1("mx_m0_wready", m0_wready, 1'b0);
    check1("mx_s_wvalid", s_wvalid, 1'b0);
    tick();
    m1_arvalid = 1'b0; m1_araddr = 32'd0;
    #1;
    check1("mx_m1_rvalid", m1_rvalid, 1'b1);
    tick();
    #1;
    check1("mx_s_wvalid_late", s_wvalid, 1'b1);
    check32("mx_s_waddr", s_waddr, 32'h20);
    check32("mx_s_wdata", s_wdata, 32'h1234_5678);
    check32("mx_s_wstrb", {28'd0, s_wstrb}, 32'hF);
    check1("mx_m0_wready_late", m0_wready, 1'b1);
    tick();
    m0_wvalid = 1'b0; m0_waddr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    #1;
    check1("mx_m0_bvalid", m0_bvalid, 1'b1);
    check1("mx_m1_bvalid", m1_bvalid, 1'b0);
    tick();

    // Backpressure: m1 holds rready low for 5 cycles while m0 waits.
    m1_rready = 1'b0;
    m1_arvalid = 1'b1; m1_araddr = 32'h20;
    sb_q.push_back('{1'b1, 1'b0, 32'h1234_5678});
    #1;
    check1("bp_m1_arready", m1_arready, 1'b1);
    tick();
    m1_arvalid = 1'b0; m1_araddr = 32'd0;
    m0_arvalid = 1'b1; m0_araddr = 32'h10;
    sb_q.push_back('{1'b0, 1'b0, 32'hCAFE_0001});
    for (int k = 0; k < 5; k++) begin
      #1;
      check1("bp_s_rvalid", s_rvalid, 1'b1);
      check1("bp_m1_rvalid", m1_rvalid, 1'b1);
      check1("bp_m0_arready", m0_arready, 1'b0);
      check1("bp_s_rready", s_rready, 1'b0);
      tick();
    end
    m1_rready = 1'b1;
    #1;
    check1("bp_s_rready_rise", s_rready, 1'b1);
    check1("bp_m0_arready_hold", m0_arready, 1'b0);
    tick();
    #1;
    check1("bp_m0_arready_after", m0_arready, 1'b1);
    tick();
    m0_arvalid = 1'b0; m0_araddr = 32'd0;
    #1;
    check1("bp_m0_rvalid", m0_rvalid, 1'b1);
    tick();

    // Asynchronous reset while waiting for read data: the response is dropped.
    m0_arvalid = 1'b1; m0_araddr = 32'h10;
    tick();
    m0_arvalid = 1'b0; m0_araddr = 32'd0;
    #1;
    check1("ar_m0_rvalid_pre", m0_rvalid, 1'b1);
    sb_rst_n = 1'b0;
    #1;
    check1("ar_m0_rvalid", m0_rvalid, 1'b0);
    check1("ar_s_rvalid", s_rvalid, 1'b0);
    check1("ar_s_rready", s_rready, 1'b0);
    check1("ar_m1_rvalid", m1_rvalid, 1'b0);
    repeat (2) tick();
    sb_rst_n = 1'b1;
    tick();
    rd_single(1'b1, 32'h10, 32'hCAFE_0001);

    tick();
    check32("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
